// File: rtl/light_avg_ctrl.sv
// Sensor front end for pwm_gen: averages a window of samples, scales to the PWM
// width, and issues a one-cycle set pulse only when the mean moves beyond HYST.
module light_avg_ctrl #(
  parameter int unsigned SAMPLE_W      = 12,
  parameter int unsigned SIZE_OF_VALUE = 8,
  parameter int unsigned LOG2_N        = 4,
  parameter int unsigned HYST          = 2,
  parameter int unsigned HOLD_CYCLES   = 256,
  parameter bit          INVERT        = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     sample_valid_i,
  input  logic [SAMPLE_W-1:0]      sample_i,
  output logic                     sample_ready_o,
  output logic                     set_o,
  output logic [SIZE_OF_VALUE-1:0] value_o
);

  localparam int unsigned AW = SAMPLE_W + LOG2_N;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD =
    HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [SIZE_OF_VALUE:0] HYST_V = (SIZE_OF_VALUE + 1)'(HYST);

  // COMMIT holds the registered hysteresis decision so the pulse lands three
  // edges after the last window handshake.
  typedef enum logic [2:0] {
    ACCUM,
    COMPUTE,
    COMPARE,
    COMMIT,
    HOLD
  } state_t;

  state_t                   state_q;
  logic [AW-1:0]            acc_q, acc_d;
  logic [LOG2_N-1:0]        cnt_q;
  logic [HW-1:0]            hold_q;
  logic [SIZE_OF_VALUE-1:0] cand_q, cand_d;
  logic [SIZE_OF_VALUE-1:0] value_q;
  logic [SIZE_OF_VALUE-1:0] diff;
  logic                     set_q;
  logic                     first_q;
  logic                     upd_q, upd_d;
  logic                     hs;

  assign sample_ready_o = rst_i && (state_q == ACCUM) && enable_i;
  assign hs             = sample_ready_o && sample_valid_i;
  assign set_o          = set_q;
  assign value_o        = value_q;

  always_comb begin
    acc_d = acc_q + AW'(sample_i);
    // Top SIZE_OF_VALUE bits of (acc >> LOG2_N) within a SAMPLE_W-wide mean.
    cand_d = acc_q[AW-1 -: SIZE_OF_VALUE];
    if (INVERT) cand_d = ~cand_d;
    diff  = (cand_q >= value_q) ? (cand_q - value_q) : (value_q - cand_q);
    upd_d = first_q || ({1'b0, diff} > HYST_V);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      cand_q  <= '0;
      value_q <= '0;
      set_q   <= 1'b0;
      first_q <= 1'b1;
      upd_q   <= 1'b0;
    end else begin
      set_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (hs) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + LOG2_N'(1);
            if (&cnt_q) state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          cand_q  <= cand_d;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= COMPARE;
        end
        COMPARE: begin
          upd_q   <= upd_d;
          state_q <= COMMIT;
        end
        COMMIT: begin
          if (upd_q) begin
            set_q   <= 1'b1;
            value_q <= cand_q;
            first_q <= 1'b0;
            hold_q  <= HOLD_LOAD;
            state_q <= (HOLD_CYCLES == 0) ? ACCUM : HOLD;
          end else begin
            state_q <= ACCUM;
          end
        end
        HOLD: begin
          if (hold_q == '0) state_q <= ACCUM;
          else              hold_q  <= hold_q - HW'(1);
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_light_avg_ctrl.sv
// Bench for light_avg_ctrl: table of averaging windows with a scoreboard of
// expected value_o updates, plus enable, reset and inverted-output sequences.
module tb_light_avg_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // default instance
  logic        rst_n, en, vld, rdy, set;
  logic [11:0] smp;
  logic [7:0]  val;
  // inverted output, no hold
  logic        i_rst_n, i_en, i_vld, i_rdy, i_set;
  logic [11:0] i_smp;
  logic [7:0]  i_val;

  light_avg_ctrl #(.SAMPLE_W(12), .SIZE_OF_VALUE(8), .LOG2_N(4), .HYST(2),
                   .HOLD_CYCLES(256), .INVERT(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en), .sample_valid_i(vld),
    .sample_i(smp), .sample_ready_o(rdy), .set_o(set), .value_o(val));

  light_avg_ctrl #(.SAMPLE_W(12), .SIZE_OF_VALUE(8), .LOG2_N(4), .HYST(2),
                   .HOLD_CYCLES(0), .INVERT(1'b1)) u_inv (
    .clk_i(clk), .rst_i(i_rst_n), .enable_i(i_en), .sample_valid_i(i_vld),
    .sample_i(i_smp), .sample_ready_o(i_rdy), .set_o(i_set), .value_o(i_val));

  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard consumer and pulse/value-stability monitor
  int         set_count    = 0;
  int         last_set_cyc = 0;
  logic       prev_set     = 1'b0;
  logic       prev_rst     = 1'b0;
  logic [7:0] prev_val     = 8'h00;
  always @(negedge clk) begin
    logic [7:0] e;
    if (set) begin
      set_count++;
      last_set_cyc = cyc;
      check("set_single", prev_set, 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL set_unexpected: value 0x%0h with no queued update", val);
      end else begin
        e = exp_q.pop_front();
        check("set_value", val, e);
      end
    end else if (rst_n && prev_rst) begin
      check("value_stable", val, prev_val);
    end
    prev_set = set;
    prev_rst = rst_n;
    prev_val = val;
  end

  task automatic send(input logic [11:0] v, output int hs_cyc);
    int n;
    n   = 0;
    smp = v;
    vld = 1'b1;
    @(negedge clk);
    while (!rdy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) check("hs_timeout", 0, 1);
    hs_cyc = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic isend(input logic [11:0] v, output int hs_cyc);
    int n;
    n     = 0;
    i_smp = v;
    i_vld = 1'b1;
    @(negedge clk);
    while (!i_rdy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!i_rdy) check("inv_hs_timeout", 0, 1);
    hs_cyc = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  // Called #1 after edge t carrying the last handshake of a window.
  task automatic finish_window(input int t, input bit upd, input int sc0,
                               input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pulses"}, set_count - sc0, int'(upd));
    if (upd) begin
      check({tag, "_lat"}, last_set_cyc - t, 3);
      check({tag, "_ready"}, cyc - t, 3 + 256);
    end else begin
      check({tag, "_ready"}, cyc - t, 3);
    end
    check({tag, "_queue"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input logic [11:0] a, input logic [11:0] b,
                            input int na, input bit upd, input logic [7:0] ev,
                            input string tag);
    int t, sc0;
    sc0 = set_count;
    if (upd) exp_q.push_back(ev);
    for (int k = 0; k < 16; k++) send((k < na) ? a : b, t);
    vld = 1'b0;
    finish_window(t, upd, sc0, tag);
  endtask

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    int          na;
    bit          upd;
    logic [7:0]  ev;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, sc0, n, ready_seen;
    logic [11:0] iv[2];
    logic [7:0]  ie[2];

    tbl[0] = '{12'h800, 12'h800, 16, 1'b1, 8'h80};  // first window
    tbl[1] = '{12'h820, 12'h820, 16, 1'b0, 8'h80};  // diff 2, held
    tbl[2] = '{12'h840, 12'h840, 16, 1'b1, 8'h84};  // diff 4
    tbl[3] = '{12'h000, 12'hFFF, 8,  1'b1, 8'h7F};  // mean 0x7FF
    tbl[4] = '{12'hFFF, 12'hFFF, 16, 1'b1, 8'hFF};  // full scale
    tbl[5] = '{12'hFFF, 12'hFFF, 16, 1'b0, 8'hFF};  // equal candidate
    tbl[6] = '{12'hFD0, 12'hFD0, 16, 1'b0, 8'hFF};  // diff 2 vs value_o
    tbl[7] = '{12'hFB0, 12'hFB0, 16, 1'b1, 8'hFB};  // diff 4 vs value_o
    tbl[8] = '{12'hFE0, 12'hFE0, 16, 1'b1, 8'hFE};  // diff 3, just over
    iv[0] = 12'hFFF; ie[0] = 8'h00;
    iv[1] = 12'h100; ie[1] = 8'hEF;

    rst_n = 1'b0; en = 1'b1; vld = 1'b0; smp = '0;
    i_rst_n = 1'b0; i_en = 1'b1; i_vld = 1'b0; i_smp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", rdy, 0);
    check("rst_set", set, 0);
    check("rst_value", val, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++)
      run_window(tbl[i].a, tbl[i].b, tbl[i].na, tbl[i].upd, tbl[i].ev,
                 $sformatf("win%0d", i));

    // window split by a disabled stretch: mean of 8x0x400 + 8x0x600 = 0x500
    sc0 = set_count;
    exp_q.push_back(8'h50);
    for (int k = 0; k < 8; k++) send(12'h400, t);
    en = 1'b0;
    smp = 12'h7FF;
    ready_seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rdy) ready_seen++;
    end
    check("en_ready_low", ready_seen, 0);
    check("en_no_pulse", set_count - sc0, 0);
    @(posedge clk);
    #1;
    en = 1'b1;
    for (int k = 0; k < 8; k++) send(12'h600, t);
    vld = 1'b0;
    finish_window(t, 1'b1, sc0, "en_split");

    // reset mid-ACCUM: partial sum and value_o lost, first_flag re-armed
    for (int k = 0; k < 5; k++) send(12'hFFF, t);
    rst_n = 1'b0;
    #1;
    check("racc_value", val, 0);
    check("racc_ready", rdy, 0);
    check("racc_set", set, 0);
    vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_window(12'h020, 12'h020, 16, 1'b1, 8'h02, "racc_first");

    // reset mid-HOLD
    sc0 = set_count;
    exp_q.push_back(8'h80);
    for (int k = 0; k < 16; k++) send(12'h800, t);
    n = 0;
    while (set_count == sc0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rhold_pulse", set_count - sc0, 1);
    repeat (20) @(negedge clk);
    check("rhold_in_hold", rdy, 0);
    rst_n = 1'b0;
    #1;
    check("rhold_value", val, 0);
    check("rhold_set", set, 0);
    check("rhold_ready", rdy, 0);
    vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rhold_ready_back", rdy, 1);
    run_window(12'h800, 12'h800, 16, 1'b1, 8'h80, "rhold_first");

    // inverted instance, HOLD_CYCLES = 0
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 16; k++) isend(iv[w], t);
      i_vld = 1'b0;
      n = 0;
      @(negedge clk);
      while (!i_set && n < 10) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("inv%0d_lat", w), cyc - t, 3);
      check($sformatf("inv%0d_value", w), i_val, ie[w]);
      check($sformatf("inv%0d_ready", w), i_rdy, 1);
      @(negedge clk);
      check($sformatf("inv%0d_single", w), i_set, 0);
      @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/light_avg_ctrl.md
Name: light_avg_ctrl

Overview:
Upstream stage of pwm_gen. Accepts raw light-sensor samples over a valid/ready handshake and averages them over a fixed window of 2^LOG2_N samples. It scales the mean to the PWM value width and applies hysteresis plus a minimum hold time. It then drives pwm_gen's set_i/value_i with a single-cycle set pulse, so the PWM counter is not restarted on every small sensor fluctuation.

Parameters:
SAMPLE_W, 12, sensor sample width in bits; must be >= SIZE_OF_VALUE.
SIZE_OF_VALUE, 8, PWM value width; matches pwm_gen.
LOG2_N, 4, log2 of averaging window length (window = 16 samples).
HYST, 2, minimum |new - current| in value LSBs required to issue an update; the difference must be strictly greater than HYST.
HOLD_CYCLES, 256, clock cycles after each update during which no samples are accepted; 0 means no hold.
INVERT, 0, 1 means output = bitwise NOT of the scaled mean (dark scene gives high duty).

Ports:
clk_i  input  1  system clock, rising edge.
rst_i  input  1  asynchronous, active-low reset; all state cleared while low.
enable_i  input  1  allows sample acceptance; does not abort an update already in progress.
sample_valid_i  input  1  sample_i holds a valid sample.
sample_i  input  SAMPLE_W  unsigned light sample.
sample_ready_o  output  1  block accepts a sample this cycle.
set_o  output  1  one-cycle pulse; connects to pwm_gen set_i.
value_o  output  SIZE_OF_VALUE  PWM value currently in force; connects to pwm_gen value_i.

Behaviour:
- Reset values while rst_i is low: state ACCUM, accumulator 0, sample count 0, hold counter 0, sample_ready_o 0, set_o 0, value_o 0, first_flag 1.
- A handshake occurs when sample_valid_i and sample_ready_o are both 1 on a rising edge.
- sample_ready_o is combinational: it equals (state == ACCUM) && enable_i.
- Accumulator width is SAMPLE_W+LOG2_N and cannot overflow.
- States:
  - ACCUM: on each handshake, acc <= acc + sample_i and cnt <= cnt + 1. When a handshake occurs with cnt == 2^LOG2_N - 1, go to COMPUTE. With enable_i low, acc and cnt hold their values; the partial window is kept, not discarded.
  - COMPUTE (1 cycle): mean = acc >> LOG2_N; cand = mean[SAMPLE_W-1 : SAMPLE_W-SIZE_OF_VALUE] (truncate LSBs); if INVERT, cand = ~cand. Register cand, clear acc and cnt, go to COMPARE.
  - COMPARE (1 cycle): diff = |cand - value_o|, computed unsigned without wrap. If first_flag or diff > HYST, then set_o <= 1, value_o <= cand, first_flag <= 0, and go to HOLD (or to ACCUM if HOLD_CYCLES == 0). Otherwise go to ACCUM; value_o is unchanged and no pulse is issued.
  - HOLD: the hold counter runs HOLD_CYCLES cycles, starting in the cycle in which set_o is high; on expiry go to ACCUM.
- set_o is registered and high for exactly one cycle. value_o changes on the same edge on which set_o rises and is stable at every other time. pwm_gen samples the two together.
- Latency: last window handshake at edge T, then COMPUTE at T+1, COMPARE at T+2, set_o/value_o visible after edge T+3.
- sample_ready_o is 0 from edge T through the end of HOLD. ACCUM, and with it ready, resumes after edge T+3+HOLD_CYCLES, or after T+3 when there is no update.
- enable_i falling in COMPUTE, COMPARE or HOLD has no effect on that sequence. Ready simply stays low on return to ACCUM.
- Hysteresis is applied relative to value_o, the last value issued, not the last candidate.
- Equal candidate with first_flag=0: diff 0, no pulse.
- Asynchronous reset in any state returns everything to reset values and re-arms first_flag, so the next completed window always issues an update.

Test Plan:
- Defaults; after reset, 16 samples of 0x800 with valid held high -> set_o single pulse 3 cycles after the 16th handshake, value_o=0x80, ready low for 256 cycles after that, then high.
- Continue with 16 x 0x820 -> cand 0x82, diff 2, not > HYST; no set_o, value_o stays 0x80. Then 16 x 0x840 -> set_o pulse, value_o=0x84.
- Window mixing 8 x 0x000 and 8 x 0xFFF -> mean 0x7FF, value_o=0x7F; check accumulator has no overflow with 16 x 0xFFF -> 0xFF.
- INVERT=1, 16 x 0xFFF -> value_o=0x00 and set_o pulses (first update); 16 x 0x100 -> value_o=0xEF.
- 8 handshakes, enable_i low for 50 cycles with valid high (ready must be 0, no accepts), then 8 more -> exactly one update with the correct mean of all 16 samples.
- rst_i pulsed low mid-HOLD and mid-ACCUM -> all outputs return to 0 immediately, partial sum lost, next full window of 0x800 issues set_o with value_o=0x80 regardless of the previous value.
